// File: rtl/reg_file_nwp.sv
`timescale 1ns/1ps
// reg_file_nwp: DEPTH x DATA_W register file with NWP prioritised write ports,
// synchronous clear, write-collision flag and a latency-1 read port (optional write-through).
module reg_file_nwp #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int NWP    = 2,
   parameter int BYPASS = 0,
   localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear_in,
   input  logic [NWP-1:0]          wen_in,
   input  logic [NWP*ADDR_W-1:0]   waddr_in,
   input  logic [NWP*DATA_W-1:0]   d_in,
   input  logic                    rd_en_in,
   input  logic [ADDR_W-1:0]       rd_addr_in,
   output logic [DEPTH*DATA_W-1:0] a_out,
   output logic [DATA_W-1:0]       rd_data_out,
   output logic                    rd_valid_out,
   output logic                    wr_collision_out
);

   logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d, view;
   logic [DEPTH-1:0]             hit_any;
   logic                         coll_d, coll_q;
   logic [DATA_W-1:0]            rd_sel, rd_data_q;
   logic                         rd_valid_q;

   // Ports scanned in ascending order so the highest-index hit wins. Out-of-range
   // addresses never match any i < DEPTH, so they neither write nor collide.
   always_comb begin
      regs_d  = regs_q;
      hit_any = '0;
      coll_d  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int p = 0; p < NWP; p++) begin
            if (wen_in[p] && (waddr_in[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
               if (hit_any[i]) coll_d = 1'b1;
               hit_any[i] = 1'b1;
               regs_d[i]  = d_in[p*DATA_W +: DATA_W];
            end
         end
      end
      if (clear_in) regs_d = '0;
   end

   assign view  = (BYPASS != 0) ? regs_d : regs_q;
   assign a_out = view;

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_in == ADDR_W'(i)) rd_sel = view[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs_q     <= '0;
         coll_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         coll_q     <= coll_d;
         rd_valid_q <= rd_en_in;
         if (rd_en_in) rd_data_q <= rd_sel;
      end
   end

   assign rd_data_out      = rd_data_q;
   assign rd_valid_out     = rd_valid_q;
   assign wr_collision_out = coll_q;

endmodule

// File: tb/tb_reg_file_nwp.sv
`timescale 1ns/1ps
// Directed bench: three builds (BYPASS=0, BYPASS=1, DEPTH=3) share one stimulus stream.
module tb_reg_file_nwp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clear_in = 1'b0;
   logic [1:0]  wen = '0;
   logic [3:0]  waddr = '0;
   logic [31:0] d = '0;
   logic        rd_en = 1'b0;
   logic [1:0]  rd_addr = '0;

   logic [63:0] a0, a1;
   logic [47:0] a2;
   logic [15:0] rdd0, rdd1, rdd2;
   logic        rdv0, rdv1, rdv2, col0, col1, col2;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   reg_file_nwp #(.DATA_W(16), .DEPTH(4), .NWP(2), .BYPASS(0)) u0 (
      .clock(clock), .reset(reset), .clear_in(clear_in), .wen_in(wen), .waddr_in(waddr),
      .d_in(d), .rd_en_in(rd_en), .rd_addr_in(rd_addr), .a_out(a0), .rd_data_out(rdd0),
      .rd_valid_out(rdv0), .wr_collision_out(col0));

   reg_file_nwp #(.DATA_W(16), .DEPTH(4), .NWP(2), .BYPASS(1)) u1 (
      .clock(clock), .reset(reset), .clear_in(clear_in), .wen_in(wen), .waddr_in(waddr),
      .d_in(d), .rd_en_in(rd_en), .rd_addr_in(rd_addr), .a_out(a1), .rd_data_out(rdd1),
      .rd_valid_out(rdv1), .wr_collision_out(col1));

   reg_file_nwp #(.DATA_W(16), .DEPTH(3), .NWP(2), .BYPASS(0)) u2 (
      .clock(clock), .reset(reset), .clear_in(clear_in), .wen_in(wen), .waddr_in(waddr),
      .d_in(d), .rd_en_in(rd_en), .rd_addr_in(rd_addr), .a_out(a2), .rd_data_out(rdd2),
      .rd_valid_out(rdv2), .wr_collision_out(col2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] w, input logic [1:0] ad1, input logic [1:0] ad0,
                     input logic [15:0] d1, input logic [15:0] d0);
      wen   = w;
      waddr = {ad1, ad0};
      d     = {d1, d0};
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // reset held across two edges
      tick(); tick();
      chk("rst_a_out", a0, 64'h0);
      chk("rst_rd_valid", {63'h0, rdv0}, 64'h0);
      chk("rst_rd_data", {48'h0, rdd0}, 64'h0);
      chk("rst_coll", {63'h0, col0}, 64'h0);
      reset = 1'b0;

      // preload all registers
      wr(2'b11, 2'd1, 2'd0, 16'h2222, 16'h1111);
      tick();
      wr(2'b11, 2'd3, 2'd2, 16'h4444, 16'h3333);
      rd_en = 1'b1; rd_addr = 2'd0;
      tick();
      chk("preload_a_out", a0, 64'h4444_3333_2222_1111);
      chk("preload_rd_data", {48'h0, rdd0}, 64'h1111);
      chk("preload_rd_valid", {63'h0, rdv0}, 64'h1);
      chk("preload_d3_a_out", {16'h0, a2}, 64'h0000_3333_2222_1111);

      // asynchronous reset between edges
      wr(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
      rd_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_a_out", a0, 64'h0);
      chk("async_rst_a_out_byp", a1, 64'h0);
      chk("async_rst_rd_valid", {63'h0, rdv0}, 64'h0);
      chk("async_rst_rd_data", {48'h0, rdd0}, 64'h0);
      chk("async_rst_coll", {63'h0, col0}, 64'h0);
      #1 reset = 1'b0;
      tick();

      // two ports, different registers
      wr(2'b11, 2'd3, 2'd1, 16'hBEEF, 16'h1234);
      tick();
      chk("dual_write_a_out", a0, 64'hBEEF_0000_1234_0000);
      chk("dual_write_coll", {63'h0, col0}, 64'h0);
      chk("d3_oob_write_a_out", {16'h0, a2}, 64'h0000_0000_1234_0000);
      chk("d3_oob_write_coll", {63'h0, col2}, 64'h0);

      // collision: port1 wins
      wr(2'b11, 2'd2, 2'd2, 16'h5555, 16'hAAAA);
      tick();
      chk("coll_a_out", a0, 64'hBEEF_5555_1234_0000);
      chk("coll_flag", {63'h0, col0}, 64'h1);
      wr(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
      tick();
      chk("coll_flag_clears", {63'h0, col0}, 64'h0);

      // read-before-write vs write-through
      wr(2'b01, 2'd0, 2'd0, 16'h0, 16'h0011);
      tick();
      wr(2'b01, 2'd0, 2'd0, 16'h0, 16'h0022);
      rd_en = 1'b1; rd_addr = 2'd0;
      #1;
      chk("byp_comb_a_out0", {48'h0, a1[15:0]}, 64'h0022);
      chk("nobyp_a_out0", {48'h0, a0[15:0]}, 64'h0011);
      tick();
      chk("rbw_rd_data", {48'h0, rdd0}, 64'h0011);
      chk("rbw_rd_valid", {63'h0, rdv0}, 64'h1);
      chk("wt_rd_data", {48'h0, rdd1}, 64'h0022);
      chk("wt_rd_valid", {63'h0, rdv1}, 64'h1);

      // idle read port holds data
      wr(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
      rd_en = 1'b0;
      tick();
      chk("idle_rd_valid", {63'h0, rdv0}, 64'h0);
      chk("idle_rd_data_hold", {48'h0, rdd0}, 64'h0011);

      // clear beats writes; collision still evaluated
      clear_in = 1'b1;
      wr(2'b11, 2'd1, 2'd1, 16'h1357, 16'hFFFF);
      #1;
      chk("clear_byp_comb", a1, 64'h0);
      tick();
      clear_in = 1'b0;
      wr(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
      chk("clear_a_out", a0, 64'h0);
      chk("clear_coll", {63'h0, col0}, 64'h1);

      // out-of-range write/read on DEPTH=3 build
      wr(2'b01, 2'd0, 2'd3, 16'h0, 16'h7777);
      rd_en = 1'b1; rd_addr = 2'd3;
      tick();
      chk("d3_oob_a_out", {16'h0, a2}, 64'h0);
      chk("d3_oob_coll", {63'h0, col2}, 64'h0);
      chk("d3_oob_rd_data", {48'h0, rdd2}, 64'h0);
      chk("d3_oob_rd_valid", {63'h0, rdv2}, 64'h1);
      chk("d4_addr3_a_out", a0, 64'h7777_0000_0000_0000);

      // back-to-back reads
      wr(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
      rd_addr = 2'd3;
      tick();
      chk("b2b_rd0_data", {48'h0, rdd0}, 64'h7777);
      chk("b2b_rd0_valid", {63'h0, rdv0}, 64'h1);
      rd_addr = 2'd0;
      tick();
      chk("b2b_rd1_data", {48'h0, rdd0}, 64'h0);
      chk("b2b_rd1_valid", {63'h0, rdv0}, 64'h1);
      rd_en = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_nwp.md
Name: reg_file_nwp

Overview:
Parametrised successor of the two-entry, single-write-port register file. It provides DEPTH registers of DATA_W bits and NWP independent write ports, with fixed priority when two ports write the same register. All register contents are exposed as one flattened bus. It adds a registered random-access read port, a synchronous clear, a write-collision flag and an optional write-through (bypass) view. It sits in the datapath wherever multi-source configuration or state registers are needed.

Parameters:
DATA_W, 16, width of each register
DEPTH, 4, number of registers (>=2, need not be a power of 2)
NWP, 2, number of write ports (>=1)
BYPASS, 0, 0 = a_out/read show registered state; 1 = a_out/read show next-state (write-through)
(localparam ADDR_W = max(1, clog2(DEPTH)))

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
clear_in  in  1  synchronous clear of all registers
wen_in  in  NWP  per-port write enable
waddr_in  in  NWP*ADDR_W  per-port write address; port p at [p*ADDR_W +: ADDR_W]
d_in  in  NWP*DATA_W  per-port write data; port p at [p*DATA_W +: DATA_W]
rd_en_in  in  1  read request
rd_addr_in  in  ADDR_W  read address
a_out  out  DEPTH*DATA_W  flattened contents; register i at [i*DATA_W +: DATA_W]
rd_data_out  out  DATA_W  registered read data
rd_valid_out  out  1  read data valid, one-cycle pulse per accepted read
wr_collision_out  out  1  registered flag: two or more enabled ports hit the same in-range address

Behaviour:
- Reset asserted, at any time, immediately forces:
  - all registers to 0
  - rd_data_out = 0, rd_valid_out = 0, wr_collision_out = 0
- Reset mid-write or mid-read discards the operation. No state survives.
- Write decode per register i:
  - Hit(p,i) = wen_in[p] && waddr_in[p] == i.
  - Winner = highest-index port p with Hit(p,i).
  - At the clock edge, reg[i] <= d_in of the winner.
  - No hit: reg[i] holds.
  - Ports writing different registers in the same cycle all take effect.
- Out-of-range write address (>= DEPTH): that port's write is ignored and it does not count toward a collision.
- clear_in = 1: all registers <= 0 at the edge. Clear overrides every write in the same cycle.
- wr_collision_out <= 1 for exactly the cycle after any register had two or more hits; otherwise 0. It is evaluated even when clear_in = 1.
- a_out, BYPASS = 0: purely the registered state. A write is visible one cycle after the edge that performs it.
- a_out, BYPASS = 1: combinational next-state view. Slice i = 0 if clear_in, else winner data if a hit exists, else reg[i].
- Read port, latency 1:
  - rd_en_in sampled high at edge k: at edge k, rd_data_out <= selected value and rd_valid_out <= 1.
  - Selected value is reg[rd_addr_in] pre-edge (read-before-write) for BYPASS = 0.
  - Selected value is the a_out slice (write-through, clear-aware) for BYPASS = 1.
  - rd_en_in low: rd_valid_out <= 0 and rd_data_out holds its last value.
  - rd_addr_in >= DEPTH: rd_data_out <= 0 and rd_valid_out <= 1.
- Back-to-back reads every cycle are supported with no bubbles.
- No X propagation: every output is defined in every cycle after reset.

Test Plan:
(defaults DATA_W=16, DEPTH=4, NWP=2, ADDR_W=2)
- Reset with registers preloaded -> a_out = 0x0000_0000_0000_0000, rd_valid_out = 0, wr_collision_out = 0 immediately on reset rise, with no clock edge needed.
- Port0 writes addr1 = 0x1234 while port1 writes addr3 = 0xBEEF in the same cycle -> next cycle a_out = 0xBEEF_0000_1234_0000 and wr_collision_out = 0.
- Both ports write addr2, port0 = 0xAAAA and port1 = 0x5555 -> reg2 = 0x5555 and wr_collision_out = 1 for one cycle, then 0.
- BYPASS=0: reg0 = 0x0011; in the same cycle write reg0 = 0x0022 and read addr0 -> rd_data_out = 0x0011, rd_valid_out = 1. With BYPASS=1 the same stimulus gives rd_data_out = 0x0022, and a_out[15:0] = 0x0022 combinationally before the edge.
- clear_in = 1 together with a port0 write of 0xFFFF to addr1 -> all registers 0 next cycle, and the write is lost.
- DEPTH=3 build: write addr3 = 0x7777 and read addr3 -> no register changes, wr_collision_out = 0, rd_data_out = 0x0000, rd_valid_out = 1.
